// File: rtl/flag_cond_unit.sv
// flag_cond_unit
// NZCV status-flag register, ARM-style condition evaluator and a small LIFO
// shadow stack for saving/restoring flags across exception entry and exit.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_negative .. i_overflow ALU flags for the current instruction
//   i_set_flags[1:0]        00 hold, 01 NZ only, 10 NZCV, 11 load i_flag_in
//   i_flag_in[3:0]          explicit {N,Z,C,V}
//   i_cond[3:0]             condition code
//   i_forward               1: evaluate on next flags, 0: on latched flags
//   i_push, i_pop           shadow-stack save / restore
//   o_flags[3:0]            latched {N,Z,C,V}
//   o_cond_true             combinational condition result
//   o_stack_empty/full      shadow-stack occupancy
//   o_stack_err             sticky overflow/underflow error
module flag_cond_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_negative,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_overflow,
  input  logic [1:0] i_set_flags,
  input  logic [3:0] i_flag_in,
  input  logic [3:0] i_cond,
  input  logic       i_forward,
  input  logic       i_push,
  input  logic       i_pop,
  output logic [3:0] o_flags,
  output logic       o_cond_true,
  output logic       o_stack_empty,
  output logic       o_stack_full,
  output logic       o_stack_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(DEPTH);
  localparam logic [PtrW:0] CntOne  = (PtrW+1)'(1);

  logic [3:0]      r_flags;
  logic [PtrW:0]   r_count;
  logic            r_err;
  logic [3:0]      r_stack [DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_pop_ok;
  logic            w_err_evt;
  logic [PtrW-1:0] w_top_idx;
  logic [PtrW-1:0] w_wr_idx;
  logic [3:0]      w_next_flags;
  logic [3:0]      w_eval_flags;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntFull);
  assign w_pop_ok  = i_pop && !w_empty;
  // Push+pop on a full stack is an exchange, not an overflow.
  assign w_err_evt = (i_pop && w_empty) || (i_push && !i_pop && w_full);
  // When full the low bits wrap to 0, so top = 0 - 1 = DEPTH-1 as required.
  assign w_top_idx = r_count[PtrW-1:0] - PtrW'(1);
  assign w_wr_idx  = r_count[PtrW-1:0];

  always_comb begin
    w_next_flags = r_flags;
    if (w_pop_ok) begin
      // A valid pop drops any SetFlags request in the same cycle.
      w_next_flags = r_stack[w_top_idx];
    end else begin
      unique case (i_set_flags)
        2'b11:   w_next_flags = i_flag_in;
        2'b10:   w_next_flags = {i_negative, i_zero, i_carry, i_overflow};
        2'b01:   w_next_flags = {i_negative, i_zero, r_flags[1:0]};
        default: w_next_flags = r_flags;
      endcase
    end
  end

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    unique case (c)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = !z;
      4'h2:    eval_cond = cy;
      4'h3:    eval_cond = !cy;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = !n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = !v;
      4'h8:    eval_cond = cy && !z;
      4'h9:    eval_cond = !cy || z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = !z && (n == v);
      4'hD:    eval_cond = z || (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  assign w_eval_flags = i_forward ? w_next_flags : r_flags;
  assign o_cond_true  = eval_cond(i_cond, w_eval_flags);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags <= 4'b0000;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_next_flags;
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
      if (w_pop_ok && i_push) begin
        // Exchange: top takes the pre-update flags, count unchanged.
        r_stack[w_top_idx] <= r_flags;
      end else if (w_pop_ok) begin
        r_count <= r_count - CntOne;
      end else if (i_push && !w_full) begin
        r_stack[w_wr_idx] <= r_flags;
        r_count           <= r_count + CntOne;
      end
    end
  end

  assign o_flags       = r_flags;
  assign o_stack_empty = w_empty;
  assign o_stack_full  = w_full;
  assign o_stack_err   = r_err;

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

  localparam int unsigned Depth = 4;

  logic       clk;
  logic       reset;
  logic       negative, zero, carry, overflow;
  logic [1:0] set_flags;
  logic [3:0] flag_in;
  logic [3:0] cond;
  logic       forward;
  logic       push, pop;
  logic [3:0] flags;
  logic       cond_true;
  logic       stack_empty, stack_full, stack_err;

  flag_cond_unit #(.DEPTH(Depth)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_negative   (negative),
    .i_zero       (zero),
    .i_carry      (carry),
    .i_overflow   (overflow),
    .i_set_flags  (set_flags),
    .i_flag_in    (flag_in),
    .i_cond       (cond),
    .i_forward    (forward),
    .i_push       (push),
    .i_pop        (pop),
    .o_flags      (flags),
    .o_cond_true  (cond_true),
    .o_stack_empty(stack_empty),
    .o_stack_full (stack_full),
    .o_stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       chk_ct;
    logic       ct;
    logic       chk_st;
    logic [3:0] flags;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference model state: flags, stack as a plain queue (back = top), error.
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err;
  logic       m_known = 1'b0;

  // Condition table written from the textual definitions.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: r = z;            1: r = !z;
      2: r = cy;           3: r = !cy;
      4: r = n;            5: r = !n;
      6: r = v;            7: r = !v;
      8: r = cy & !z;      9: r = !cy | z;
      10: r = (n == v);    11: r = (n != v);
      12: r = !z & (n == v);
      13: r = z | (n != v);
      14: r = 1;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_ct) check("cond_true", {3'b0, cond_true}, {3'b0, e.ct});
      if (e.chk_st) begin
        check("flags", flags, e.flags);
        check("stack_empty", {3'b0, stack_empty}, {3'b0, e.empty});
        check("stack_full", {3'b0, stack_full}, {3'b0, e.full});
        check("stack_err", {3'b0, stack_err}, {3'b0, e.err});
      end
    end
  end

  // Drive one cycle of stimulus and queue what the outputs must show.
  task automatic step(input logic rst, input logic [1:0] sf, input logic [3:0] fin,
                      input logic [3:0] nzcv, input logic [3:0] c, input logic fwd,
                      input logic ps, input logic pp);
    exp_t       e;
    logic [3:0] nf;
    bit         pop_ok;
    @(posedge clk);
    #1;
    reset = rst; set_flags = sf; flag_in = fin;
    {negative, zero, carry, overflow} = nzcv;
    cond = c; forward = fwd; push = ps; pop = pp;

    pop_ok = pp && (m_stack.size() > 0);
    if (pop_ok)          nf = m_stack[m_stack.size()-1];
    else if (sf == 2'b11) nf = fin;
    else if (sf == 2'b10) nf = nzcv;
    else if (sf == 2'b01) nf = {nzcv[3:2], m_flags[1:0]};
    else                 nf = m_flags;

    e.chk_ct = m_known && !rst;
    e.ct     = ref_cond(c, fwd ? nf : m_flags);
    e.chk_st = m_known;
    e.flags  = m_flags;
    e.empty  = (m_stack.size() == 0);
    e.full   = (m_stack.size() == Depth);
    e.err    = m_err;
    exp_q.push_back(e);

    if (rst) begin
      m_stack.delete();
      m_flags = 4'b0000;
      m_err   = 1'b0;
      m_known = 1'b1;
    end else begin
      if ((pp && m_stack.size() == 0) || (ps && !pp && m_stack.size() == Depth)) m_err = 1'b1;
      if (pop_ok && ps)                     m_stack[m_stack.size()-1] = m_flags;
      else if (pop_ok)                      void'(m_stack.pop_back());
      else if (ps && m_stack.size() < Depth) m_stack.push_back(m_flags);
      m_flags = nf;
    end
  endtask

  // Shorthands: hold-with-condition, and load-flags cycle.
  task automatic idle(input logic [3:0] c, input logic fwd);
    step(1'b0, 2'b00, 4'h0, 4'h0, c, fwd, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [3:0] v, input logic ps, input logic pp);
    step(1'b0, 2'b11, v, 4'h0, 4'hE, 1'b0, ps, pp);
  endtask

  initial begin
    reset = 1'b1; set_flags = 2'b00; flag_in = 4'h0;
    {negative, zero, carry, overflow} = 4'h0;
    cond = 4'h0; forward = 1'b0; push = 1'b0; pop = 1'b0;

    // Reset state and constant conditions.
    step(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    idle(4'h0, 1'b0);
    idle(4'hE, 1'b0);
    idle(4'hF, 1'b0);

    // Full update, then NZ-only update keeping C and V.
    step(1'b0, 2'b10, 4'h0, 4'b0110, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 4'h0, 4'b1001, 4'h0, 1'b0, 1'b0, 1'b0);
    idle(4'h0, 1'b0);

    // Forwarding: same SetFlags request seen with Forward=1 and Forward=0.
    load(4'b0000, 1'b0, 1'b0);
    step(1'b0, 2'b10, 4'h0, 4'b0100, 4'h0, 1'b1, 1'b0, 1'b0);
    load(4'b0000, 1'b0, 1'b0);
    step(1'b0, 2'b10, 4'h0, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);

    // Sweep every condition against every flag value, both paths.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        step(1'b0, 2'b11, 4'(f), 4'h0, 4'(c), 1'b1, 1'b0, 1'b0);
      end
      for (int c = 0; c < 16; c++) idle(4'(c), 1'b0);
    end

    // Pop overrides SetFlags.
    load(4'b0110, 1'b0, 1'b0);
    step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    load(4'b1001, 1'b0, 1'b0);
    step(1'b0, 2'b10, 4'h0, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(4'h0, 1'b0);

    // Fill, overflow, then drain in reverse order.
    load(4'b0001, 1'b0, 1'b0);
    load(4'b0010, 1'b1, 1'b0);
    load(4'b0100, 1'b1, 1'b0);
    load(4'b1000, 1'b1, 1'b0);
    load(4'b1111, 1'b1, 1'b0);
    load(4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(4'h0, 1'b0);

    // Exchange, underflow, reset clears error and discards entries.
    step(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    load(4'b1100, 1'b0, 1'b0);
    load(4'b0011, 1'b1, 1'b0);
    step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    load(4'b1010, 1'b1, 1'b0);
    step(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(4'h0, 1'b0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) == 0), 2'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(4'h0, 1'b0);

    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
